// File: rtl/logic_unit_pkg.sv
// Shared op codes, defaults and the bitwise
// result function for the debounced logic unit.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NOT_A  = 3'd3;
  localparam logic [2:0] OP_NAND   = 3'd4;
  localparam logic [2:0] OP_NOR    = 3'd5;
  localparam logic [2:0] OP_XNOR   = 3'd6;
  localparam logic [2:0] OP_PASS_A = 3'd7;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  function automatic logic [31:0] logic_op(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    r = '0;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NOT_A:  r = ~a;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XNOR:   r = ~(a ^ b);
      OP_PASS_A: r = a;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One-bit two-flop synchroniser followed by a
// disagreement counter that gates the stable level.
module debounce_cell
  import logic_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // plain two-flop synchroniser, nothing between the stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // count consecutive disagreeing cycles; accept on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/debounced_logic_unit.sv
// Debounced two-bus push-button logic unit with
// registered LED result, press pulses and change strobe.
module debounced_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_a,
  input  logic [WIDTH-1:0] btn_b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] a_stable,
  output logic [WIDTH-1:0] b_stable,
  output logic [WIDTH-1:0] a_press,
  output logic [WIDTH-1:0] led_result,
  output logic             result_changed
);

  logic [WIDTH-1:0] a_prev;
  logic [WIDTH-1:0] led_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_a[i]),
      .stable(a_stable[i])
    );
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_b[i]),
      .stable(b_stable[i])
    );
  end

  // a_stable one cycle old, so a press shows for the cycle after it rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) a_prev <= '0;
    else        a_prev <= a_stable;
  end

  assign a_press = a_stable & ~a_prev;

  // bitwise result of the current op on the debounced operands
  always_comb begin
    led_next = WIDTH'(logic_op(op, 32'(a_stable), 32'(b_stable)));
  end

  // single result update per edge plus a strobe when it differs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_result     <= '0;
      result_changed <= 1'b0;
    end else begin
      led_result     <= led_next;
      result_changed <= (led_next != led_result);
    end
  end

endmodule

// File: tb/tb_debounced_logic_unit.sv
// Directed bench for debounced_logic_unit,
// WIDTH=4 and DEBOUNCE_CYCLES=4.
module tb_debounced_logic_unit;
  import logic_unit_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_a;
  logic [3:0] btn_b;
  logic [2:0] op;
  logic [3:0] a_stable;
  logic [3:0] b_stable;
  logic [3:0] a_press;
  logic [3:0] led_result;
  logic       result_changed;

  int total = 0;
  int bad   = 0;

  debounced_logic_unit #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_a         (btn_a),
    .btn_b         (btn_b),
    .op            (op),
    .a_stable      (a_stable),
    .b_stable      (b_stable),
    .a_press       (a_press),
    .led_result    (led_result),
    .result_changed(result_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] ops  [7];
    logic [3:0] exps [7];
    int glitch_bad;
    int presses;

    ops  = '{OP_AND, OP_OR, OP_NAND, OP_NOR,
             OP_XNOR, OP_NOT_A, OP_PASS_A};
    exps = '{4'b0001, 4'b0111, 4'b1110, 4'b1000,
             4'b1001, 4'b1100, 4'b0011};

    // 1: reset with random inputs
    rst_n = 1'b0;
    btn_a = 4'($urandom);
    btn_b = 4'($urandom);
    op    = 3'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_a_stable", a_stable, 4'b0);
    chk("rst_b_stable", b_stable, 4'b0);
    chk("rst_a_press", a_press, 4'b0);
    chk("rst_led", led_result, 4'b0);
    chk("rst_rc", {3'b0, result_changed}, 4'b0);
    btn_a = '0;
    btn_b = '0;
    op    = OP_AND;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("rel_led", led_result, 4'b0);
      chk("rel_rc", {3'b0, result_changed}, 4'b0);
    end

    // 2: XOR of 0011 and 0101
    btn_a = 4'b0011;
    btn_b = 4'b0101;
    op    = OP_XOR;
    repeat (5) @(negedge clk);
    chk("xor_a_early", a_stable, 4'b0);
    chk("xor_b_early", b_stable, 4'b0);
    @(negedge clk);
    chk("xor_a_stable", a_stable, 4'b0011);
    chk("xor_b_stable", b_stable, 4'b0101);
    chk("xor_press", a_press, 4'b0011);
    chk("xor_led_early", led_result, 4'b0);
    @(negedge clk);
    chk("xor_led", led_result, 4'b0110);
    chk("xor_rc", {3'b0, result_changed}, 4'b0001);
    chk("xor_press_end", a_press, 4'b0);
    @(negedge clk);
    chk("xor_rc_end", {3'b0, result_changed}, 4'b0);

    // 3: three-cycle glitch on btn_a[2]
    glitch_bad = 0;
    for (int i = 0; i < 13; i++) begin
      btn_a = (i < 3) ? 4'b0111 : 4'b0011;
      @(negedge clk);
      if (a_stable !== 4'b0011 || a_press !== 4'b0 ||
          led_result !== 4'b0110)
        glitch_bad++;
    end
    chk("glitch", 4'(glitch_bad), 4'b0);

    // 4: bounce btn_a[0] then settle high
    btn_a = 4'b0010;
    repeat (10) @(negedge clk);
    chk("bnc_pre", a_stable, 4'b0010);
    presses = 0;
    for (int i = 0; i < 10; i++) begin
      btn_a[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
      repeat (2) begin
        @(negedge clk);
        presses += int'(a_press[0]);
      end
    end
    chk("bnc_during", a_stable, 4'b0010);
    btn_a[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      presses += int'(a_press[0]);
    end
    chk("bnc_early", a_stable, 4'b0010);
    @(negedge clk);
    presses += int'(a_press[0]);
    chk("bnc_rise", a_stable, 4'b0011);
    chk("bnc_press", a_press, 4'b0001);
    repeat (4) begin
      @(negedge clk);
      presses += int'(a_press[0]);
    end
    chk("bnc_count", 4'(presses), 4'd1);
    chk("bnc_led", led_result, 4'b0110);

    // 5: op sweep on 0011 / 0101
    for (int k = 0; k < 7; k++) begin
      op = ops[k];
      @(negedge clk);
      chk($sformatf("op%0d_led", ops[k]), led_result, exps[k]);
      chk($sformatf("op%0d_rc", ops[k]),
          {3'b0, result_changed}, 4'b0001);
      @(negedge clk);
      chk($sformatf("op%0d_rc_end", ops[k]),
          {3'b0, result_changed}, 4'b0);
    end

    // 6: reset in the middle of a debounce count
    btn_a = 4'b1111;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_a_stable", a_stable, 4'b0);
    chk("mid_b_stable", b_stable, 4'b0);
    chk("mid_led", led_result, 4'b0);
    chk("mid_rc", {3'b0, result_changed}, 4'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_a_early", a_stable, 4'b0);
    @(negedge clk);
    chk("mid_a_back", a_stable, 4'b1111);
    chk("mid_b_back", b_stable, 4'b0101);
    chk("mid_press", a_press, 4'b1111);
    @(negedge clk);
    chk("mid_led_back", led_result, 4'b1111);
    chk("mid_rc_back", {3'b0, result_changed}, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
